vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/pix_tick_gen.sv | 38 +++
 rtl/vga_timing.sv | 123 ++++++++++++
 tb/tb_vga_timing.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, sync windows and pixel colour type
package vga_pkg;

   // Counter width shared by the timing core and the graphics stage
   localparam int CNT_W = 10;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   // Default 640x480@60 geometry
   localparam int CLK_DIV_DEF  = 2;
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   // Inclusive sync windows for the default geometry
   localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
   localparam int H_SYNC_END   = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF - 1;
   localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
   localparam int V_SYNC_END   = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF - 1;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   // True when c lies in the inclusive window [lo, hi]
   function automatic logic in_window(input logic [CNT_W-1:0] c,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (c >= lo) && (c <= hi);
   endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// rtl/pix_tick_gen.sv - divides the system clock down to a one-clock pixel tick
module pix_tick_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   output logic pix_en
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q;
   logic [DW-1:0] div_d;

   // Next divider value: count up and wrap after the last phase
   always_comb begin
      div_d = div_q + DW'(1);
      if (div_q == LAST) begin
         div_d = '0;
      end
   end

   // Divider register, cleared immediately on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   // Tick on the last phase; reset holds div_q at 0 so no tick during reset
   assign pix_en = (div_q == LAST);

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster counters, sync decode and registered pixel output
module vga_timing
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = CLK_DIV_DEF,
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] hc,
   output logic [CNT_W-1:0] vc,
   output logic             pix_en,
   output logic             active,
   output logic             frame_start,
   input  logic [2:0]       red_in,
   input  logic [2:0]       green_in,
   input  logic [1:0]       blue_in,
   output logic             vga_hs,
   output logic             vga_vs,
   output logic [2:0]       vga_r,
   output logic [2:0]       vga_g,
   output logic [1:0]       vga_b
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Geometry must fit the 10-bit counters and the divider range
   if (H_TOT > CNT_MAX || V_TOT > CNT_MAX) begin : g_bad_geometry
      $error("vga_timing: H or V total exceeds counter range");
   end
   if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_bad_clk_div
      $error("vga_timing: CLK_DIV must be 2..16");
   end

   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
   localparam logic [CNT_W-1:0] H_ACT_L = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_L = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [CNT_W-1:0] hc_q, hc_d;
   logic [CNT_W-1:0] vc_q, vc_d;
   logic             hs_n, vs_n;
   logic             hs_q, vs_q;
   rgb332_t          rgb_in, rgb_q;

   pix_tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .pix_en (pix_en)
   );

   // Raster advance: hc steps per pixel tick, vc steps when hc wraps
   always_comb begin
      hc_d = hc_q;
      vc_d = vc_q;
      if (pix_en) begin
         if (hc_q == H_LAST) begin
            hc_d = '0;
            if (vc_q == V_LAST) begin
               vc_d = '0;
            end else begin
               vc_d = vc_q + CNT_W'(1);
            end
         end else begin
            hc_d = hc_q + CNT_W'(1);
         end
      end
   end

   // Raster counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hc_q <= '0;
         vc_q <= '0;
      end else begin
         hc_q <= hc_d;
         vc_q <= vc_d;
      end
   end

   assign hc          = hc_q;
   assign vc          = vc_q;
   assign active      = (hc_q < H_ACT_L) && (vc_q < V_ACT_L);
   assign frame_start = pix_en && (hc_q == '0) && (vc_q == '0);

   assign hs_n   = ~in_window(hc_q, HS_LO, HS_HI);
   assign vs_n   = ~in_window(vc_q, VS_LO, VS_HI);
   assign rgb_in = '{r: red_in, g: green_in, b: blue_in};

   // Output stage: sample syncs and blanked colour once per pixel tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         rgb_q <= '0;
      end else if (pix_en) begin
         hs_q  <= hs_n;
         vs_q  <= vs_n;
         rgb_q <= active ? rgb_in : '0;
      end
   end

   assign vga_hs = hs_q;
   assign vga_vs = vs_q;
   assign vga_r  = rgb_q.r;
   assign vga_g  = rgb_q.g;
   assign vga_b  = rgb_q.b;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - scoreboard bench for vga_timing at default and reduced geometry
module tb_vga_timing;
   import vga_pkg::*;

   typedef struct packed {
      logic [31:0] cyc;
      logic [9:0]  hc;
      logic [9:0]  vc;
      logic        act;
      logic        fs;
      logic        hs;
      logic        vs;
      logic [7:0]  rgb;
   } obs_t;

   localparam logic [32:0] RST_EXP = {10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
   localparam logic [7:0]  RGB_A   = 8'b111_111_11;
   localparam logic [7:0]  RGB_B   = 8'b101_010_01;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   logic [9:0] a_hc, a_vc, b_hc, b_vc;
   logic a_pix, a_act, a_fs, a_hs, a_vs, b_pix, b_act, b_fs, b_hs, b_vs;
   logic [2:0] a_r, a_g, b_r, b_g;
   logic [1:0] a_b, b_b;
   logic [2:0] a_ri, a_gi, b_ri, b_gi;
   logic [1:0] a_bi, b_bi;

   vga_timing dut_a (
      .clk(clk), .rst(rst_a), .hc(a_hc), .vc(a_vc), .pix_en(a_pix), .active(a_act),
      .frame_start(a_fs), .red_in(a_ri), .green_in(a_gi), .blue_in(a_bi),
      .vga_hs(a_hs), .vga_vs(a_vs), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b)
   );

   vga_timing #(
      .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2)
   ) dut_b (
      .clk(clk), .rst(rst_b), .hc(b_hc), .vc(b_vc), .pix_en(b_pix), .active(b_act),
      .frame_start(b_fs), .red_in(b_ri), .green_in(b_gi), .blue_in(b_bi),
      .vga_hs(b_hs), .vga_vs(b_vs), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b)
   );

   int n_cmp = 0;
   int n_bad = 0;
   obs_t qa[$];
   obs_t qb[$];
   int cyc_a, cyc_b, ka, kb;
   logic run_a = 1'b0, run_b = 1'b0;
   int hs_low_a = 0, hs_fall_hc = -1, vs_low_b = 0, hold_viol = 0;
   int fs_n = 0;
   int fs_cyc[4];
   logic prev_pix_b = 1'b1;
   logic [9:0] prev_out_b = '0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", nm, got, exp);
      end
   endtask

   // Expected observation at the k-th pixel tick after reset release
   function automatic obs_t model(input int k, input int div,
                                  input int ha, input int hf, input int hw, input int hb,
                                  input int va, input int vf, input int vw, input int vb,
                                  input logic [7:0] rgb);
      obs_t e;
      int ht, vt, ph, pv;
      ht = ha + hf + hw + hb;
      vt = va + vf + vw + vb;
      e.cyc = 32'(div * (k + 1) - 1);
      e.hc  = 10'(k % ht);
      e.vc  = 10'((k / ht) % vt);
      e.act = ((k % ht) < ha) && (((k / ht) % vt) < va);
      e.fs  = (k % (ht * vt)) == 0;
      if (k == 0) begin
         e.hs = 1'b1; e.vs = 1'b1; e.rgb = 8'h00;
      end else begin
         ph = (k - 1) % ht;
         pv = ((k - 1) / ht) % vt;
         e.hs  = !((ph >= ha + hf) && (ph < ha + hf + hw));
         e.vs  = !((pv >= va + vf) && (pv < va + vf + vw));
         e.rgb = ((ph < ha) && (pv < va)) ? rgb : 8'h00;
      end
      return e;
   endfunction

   // Clock counters since reset release
   always @(posedge clk or posedge rst_a) begin
      if (rst_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;
   end
   always @(posedge clk or posedge rst_b) begin
      if (rst_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;
   end

   // Monitor A: compare each pixel tick against the scoreboard
   always @(negedge clk) begin
      obs_t e, g;
      if (!rst_a && a_pix && qa.size() > 0) begin
         e = qa.pop_front();
         g.cyc = cyc_a; g.hc = a_hc; g.vc = a_vc; g.act = a_act; g.fs = a_fs;
         g.hs = a_hs; g.vs = a_vs; g.rgb = {a_r, a_g, a_b};
         chk($sformatf("tickA k=%0d", ka), g, e);
         ka++;
         if (run_a && a_vc == 10'd0 && !a_hs) begin
            if (hs_low_a == 0) hs_fall_hc = int'(a_hc);
            hs_low_a++;
         end
      end
   end

   // Monitor B: scoreboard plus sync, frame period and hold tracking
   always @(negedge clk) begin
      obs_t e, g;
      if (!rst_b) begin
         if (!prev_pix_b && {b_hs, b_vs, b_r, b_g, b_b} !== prev_out_b) hold_viol++;
         if (b_pix && qb.size() > 0) begin
            e = qb.pop_front();
            g.cyc = cyc_b; g.hc = b_hc; g.vc = b_vc; g.act = b_act; g.fs = b_fs;
            g.hs = b_hs; g.vs = b_vs; g.rgb = {b_r, b_g, b_b};
            chk($sformatf("tickB k=%0d", kb), g, e);
            kb++;
            if (run_b && !b_vs) vs_low_b++;
            if (run_b && b_fs) begin
               if (fs_n < 4) fs_cyc[fs_n] = cyc_b;
               fs_n++;
            end
         end
      end
      prev_pix_b = b_pix;
      prev_out_b = {b_hs, b_vs, b_r, b_g, b_b};
   end

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      {a_ri, a_gi, a_bi} = RGB_A;
      {b_ri, b_gi, b_bi} = RGB_B;
      ka = 0; kb = 0;
      for (int i = 0; i < 4; i++) fs_cyc[i] = 0;
      repeat (3) @(negedge clk);
      chk("reset A", 64'({a_hc, a_vc, a_pix, a_act, a_fs, a_hs, a_vs, a_r, a_g, a_b}), 64'(RST_EXP));
      chk("reset B", 64'({b_hc, b_vc, b_pix, b_act, b_fs, b_hs, b_vs, b_r, b_g, b_b}), 64'(RST_EXP));

      for (int k = 0; k < 2400; k++) qa.push_back(model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, RGB_A));
      for (int k = 0; k < 651; k++) qb.push_back(model(k, 4, 16, 2, 4, 3, 8, 1, 2, 2, RGB_B));
      run_a = 1'b1; run_b = 1'b1;
      rst_a = 1'b0; rst_b = 1'b0;
      for (int i = 0; i < 6000 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
      run_a = 1'b0; run_b = 1'b0;
      chk("drain A", 64'(qa.size()), 64'd0);
      chk("drain B", 64'(qb.size()), 64'd0);
      chk("hs low ticks A", 64'(hs_low_a), 64'd96);
      chk("hs fall hc A", 64'(hs_fall_hc), 64'd657);
      chk("vs low ticks B", 64'(vs_low_b), 64'd100);
      chk("frame starts B", 64'(fs_n), 64'd3);
      chk("first fs clk B", 64'(fs_cyc[0]), 64'd3);
      chk("frame period B", 64'(fs_cyc[1] - fs_cyc[0]), 64'd1300);
      chk("hold B", 64'(hold_viol), 64'd0);

      for (int i = 0; i < 2000 && a_hc != 10'd300; i++) @(negedge clk);
      chk("seek hc300 A", 64'(a_hc), 64'd300);
      chk("midline vc A", 64'(a_vc == 10'd0), 64'd0);
      #2 rst_a = 1'b1;
      #1 chk("async reset A", 64'({a_hc, a_vc, a_pix, a_act, a_fs, a_hs, a_vs, a_r, a_g, a_b}), 64'(RST_EXP));
      repeat (2) @(negedge clk);
      ka = 0;
      for (int k = 0; k < 900; k++) qa.push_back(model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, RGB_A));
      rst_a = 1'b0;
      for (int i = 0; i < 3000 && qa.size() != 0; i++) @(negedge clk);
      chk("drain A restart", 64'(qa.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
